uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that sits directly downstream of the RISCV core's data-bus store path, beside the GPIO output port. The core writes a byte to the DATA register. The block serialises it as 8N1 on `tx` at a fixed baud derived from `clk`. A STATUS register lets firmware poll for completion and detect dropped writes.

---
 rtl/uart_tx_mmio.sv | 143 ++++++++++++++
 tb/tb_uart_tx_mmio.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter on the core's store path.
// Latency: an accepted DATA write puts the start bit on tx in the cycle right
//   after the write edge; a frame is exactly 10*CLKS_PER_BIT cycles long.
// Backpressure: none; a DATA write while busy is dropped and sets the sticky
//   overrun flag, which firmware clears by writing STATUS with wdata[1]=1.
// Ports: clk/reset (sync, active-high); addr/wdata/we bus write side;
//   rdata combinational STATUS read {30'b0, overrun, busy}; tx serial line
//   (idles high); busy high for START/DATA/STOP.
module uart_tx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [31:0] ADDR_DATA    = 32'h1001_0030,
  parameter logic [31:0] ADDR_STATUS  = 32'h1001_0034
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             overrun_q, overrun_d;

  logic wrap;
  logic data_wr;
  logic status_wr;
  logic accept;

  // Only wdata[7:0] (DATA) and wdata[1] (STATUS) carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  assign wrap      = (cnt_q == CNT_MAX);
  assign data_wr   = we && (addr == ADDR_DATA);
  assign status_wr = we && (addr == ADDR_STATUS);

  // A write landing on the final stop-bit edge is taken as the next frame,
  // which is what makes back-to-back frames gapless.
  assign accept = data_wr && ((state_q == IDLE) || ((state_q == STOP) && wrap));

  always_comb begin
    state_d   = state_q;
    cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    overrun_d = overrun_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
      end
      START: begin
        if (wrap) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (wrap) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (wrap) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      state_d   = START;
      shift_d   = wdata[7:0];
      cnt_d     = '0;
      bit_idx_d = '0;
    end

    if (data_wr && !accept) begin
      overrun_d = 1'b1;
    end
    if (status_wr && wdata[1]) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      overrun_q <= overrun_d;
    end
  end

  // tx decodes registered state only, so there is no path from we to tx.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    rdata = '0;
    if (addr == ADDR_STATUS) begin
      rdata = {30'b0, overrun_q, busy};
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

  localparam logic [31:0] A_DATA   = 32'h1001_0030;
  localparam logic [31:0] A_STATUS = 32'h1001_0034;
  localparam logic [31:0] A_OTHER  = 32'h1001_0038;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic [31:0] addr, wdata;
  logic        we, we2;
  logic [31:0] rdata, rdata2;
  logic        tx, tx2, busy, busy2;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_mmio #(.CLKS_PER_BIT(4), .ADDR_DATA(A_DATA), .ADDR_STATUS(A_STATUS)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .tx(tx), .busy(busy)
  );

  uart_tx_mmio #(.CLKS_PER_BIT(2), .ADDR_DATA(A_DATA), .ADDR_STATUS(A_STATUS)) dut2 (
    .clk(clk), .reset(reset2), .addr(addr), .wdata(wdata), .we(we2),
    .rdata(rdata2), .tx(tx2), .busy(busy2)
  );

  // One record: drive inputs for one edge, then expect the same outputs
  // for 'hold' consecutive cycles (reset stays applied for all of them).
  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic        etx;
    logic        ebusy;
    logic [31:0] erd;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input int h, input logic et,
                              input logic eb, input logic [31:0] er, input string nm);
    vec_t x;
    x.rst = r; x.we = w; x.addr = a; x.wdata = d; x.hold = h;
    x.etx = et; x.ebusy = eb; x.erd = er; x.name = nm;
    return x;
  endfunction

  task automatic apply(input vec_t x);
    reset = x.rst; we = x.we; addr = x.addr; wdata = x.wdata;
    for (int i = 0; i < x.hold; i++) begin
      @(posedge clk); #1;
      we = 1'b0; addr = A_STATUS; wdata = '0;
      @(negedge clk);
      n_vec++;
      if (tx !== x.etx || busy !== x.ebusy || rdata !== x.erd) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got tx=%b busy=%b rdata=%h, want tx=%b busy=%b rdata=%h",
                 x.name, i, tx, busy, rdata, x.etx, x.ebusy, x.erd);
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  initial begin
    logic [9:0] frame;
    int e_cyc;
    bit done;

    reset = 1'b1; reset2 = 1'b1;
    we = 1'b0; we2 = 1'b0; addr = A_STATUS; wdata = '0;

    // Reset
    vecs.push_back(mk(1, 0, A_STATUS, 0, 3, 1, 0, 32'h0, "reset"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 2, 1, 0, 32'h0, "idle"));
    // Single frame 8'hA5: bits 1,0,1,0,0,1,0,1
    vecs.push_back(mk(0, 1, A_DATA, 32'hA5, 4, 0, 1, 32'h1, "a5_start"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 4, 1, 1, 32'h1, "a5_d0"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 4, 0, 1, 32'h1, "a5_d1"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 4, 1, 1, 32'h1, "a5_d2"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 8, 0, 1, 32'h1, "a5_d3d4"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 4, 1, 1, 32'h1, "a5_d5"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 4, 0, 1, 32'h1, "a5_d6"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 8, 1, 1, 32'h1, "a5_d7stop"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 3, 1, 0, 32'h0, "a5_after"));
    // Back-to-back 8'h00 then 8'hFF at E+40
    vecs.push_back(mk(0, 1, A_DATA, 32'h00, 36, 0, 1, 32'h1, "b2b_00_start_data"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 4, 1, 1, 32'h1, "b2b_00_stop"));
    vecs.push_back(mk(0, 1, A_DATA, 32'hFF, 4, 0, 1, 32'h1, "b2b_ff_start"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 36, 1, 1, 32'h1, "b2b_ff_data_stop"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 2, 1, 0, 32'h0, "b2b_after"));
    // Overrun: 8'h3C (bits 0,0,1,1,1,1,0,0), 8'h55 written at E+10
    vecs.push_back(mk(0, 1, A_DATA, 32'h3C, 4, 0, 1, 32'h1, "ovr_start"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 6, 0, 1, 32'h1, "ovr_d0d1a"));
    vecs.push_back(mk(0, 1, A_DATA, 32'h55, 2, 0, 1, 32'h3, "ovr_write"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 16, 1, 1, 32'h3, "ovr_d2d5"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 8, 0, 1, 32'h3, "ovr_d6d7"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 4, 1, 1, 32'h3, "ovr_stop"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 2, 1, 0, 32'h2, "ovr_after"));
    vecs.push_back(mk(0, 1, A_STATUS, 32'hFFFF_FFFD, 1, 1, 0, 32'h2, "ovr_noclear"));
    vecs.push_back(mk(0, 1, A_STATUS, 32'h2, 2, 1, 0, 32'h0, "ovr_clear"));
    // Reset mid-frame: 8'h81 (bits 1,0,0,0,0,0,0,1), reset at E+17
    vecs.push_back(mk(0, 1, A_DATA, 32'h81, 4, 0, 1, 32'h1, "rmf_start"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 4, 1, 1, 32'h1, "rmf_d0"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 9, 0, 1, 32'h1, "rmf_d1d3"));
    vecs.push_back(mk(1, 0, A_STATUS, 0, 1, 1, 0, 32'h0, "rmf_reset"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 2, 1, 0, 32'h0, "rmf_idle"));
    vecs.push_back(mk(0, 1, A_DATA, 32'h81, 4, 0, 1, 32'h1, "rmf2_start"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 4, 1, 1, 32'h1, "rmf2_d0"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 24, 0, 1, 32'h1, "rmf2_d1d6"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 8, 1, 1, 32'h1, "rmf2_d7stop"));
    vecs.push_back(mk(0, 0, A_STATUS, 0, 2, 1, 0, 32'h0, "rmf2_after"));
    // Unmapped write while idle
    vecs.push_back(mk(0, 1, A_OTHER, 32'hA5, 3, 1, 0, 32'h0, "unmapped_idle"));

    @(negedge clk);
    foreach (vecs[i]) apply(vecs[i]);

    // Read decode while busy, unmapped write while busy, frame length.
    we = 1'b1; addr = A_DATA; wdata = 32'h12;
    @(posedge clk); #1;
    e_cyc = cyc;
    we = 1'b0; wdata = '0;
    @(negedge clk);
    addr = A_DATA;   #1; check("rdata_data_addr", rdata, 32'h0);
    addr = A_OTHER;  #1; check("rdata_other_addr", rdata, 32'h0);
    addr = A_STATUS; #1; check("rdata_status_busy", rdata, 32'h1);
    we = 1'b1; addr = A_OTHER; wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    we = 1'b0; addr = A_STATUS; wdata = '0;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    check("frame_done", 32'(done), 32'h1);
    check("frame_len_c4", 32'(cyc - e_cyc), 32'd40);
    check("status_after_unmapped", rdata, 32'h0);
    check("tx_idle_after", 32'(tx), 32'h1);

    // C=2 instance: frame of 8'h01 is 20 cycles, LSB first.
    @(negedge clk);
    reset2 = 1'b0;
    @(negedge clk);
    check("c2_reset_tx", 32'(tx2), 32'h1);
    check("c2_reset_busy", 32'(busy2), 32'h0);
    frame = {1'b1, 8'h01, 1'b0};
    we2 = 1'b1; addr = A_DATA; wdata = 32'h01;
    @(posedge clk); #1;
    we2 = 1'b0; addr = A_STATUS; wdata = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_vec++;
      if (tx2 !== frame[c / 2] || busy2 !== 1'b1 || rdata2 !== 32'h1) begin
        n_fail++;
        $display("FAIL c2_frame cycle %0d: got tx=%b busy=%b rdata=%h, want tx=%b busy=1 rdata=1",
                 c, tx2, busy2, rdata2, frame[c / 2]);
      end
    end
    @(negedge clk);
    check("c2_after_busy", 32'(busy2), 32'h0);
    check("c2_after_tx", 32'(tx2), 32'h1);
    check("c2_after_status", rdata2, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
